// File: rtl/adder_input_sequencer.sv
// ---------------------------------------------------------------------------
// adder_input_sequencer
//
// Sequential front/back end for a combinational WIDTH-bit ripple adder.
// Two operands are captured from slide switches on successive presses of a
// load button and driven onto the adder inputs. One cycle later the adder's
// sum and carry-out are sampled into a registered result for display.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous, active-low reset
//   sw           operand value from slide switches (quasi-static)
//   btn_load     raw asynchronous load button, active-high
//   btn_clear    raw asynchronous clear button, active-high
//   add_x        operand A to adder X input (registered)
//   add_y        operand B to adder Y input (registered)
//   add_s        adder sum
//   add_cout     adder carry-out
//   result       registered {carry, sum}
//   result_valid high while result holds a completed sum
//   state        FSM state encoding, for LEDs
//   ops_count    number of completed additions (wraps silently)
// ---------------------------------------------------------------------------
module adder_input_sequencer #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     sw,
  input  logic                 btn_load,
  input  logic                 btn_clear,
  output logic [WIDTH-1:0]     add_x,
  output logic [WIDTH-1:0]     add_y,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_cout,
  output logic [WIDTH:0]       result,
  output logic                 result_valid,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] ops_count
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_SUM  = 2'b10,
    S_SHOW = 2'b11
  } state_e;

  // -------------------------------------------------------------------------
  // Button conditioning: synchronizer chain, then a registered rising-edge
  // detector so each press yields exactly one 1-cycle pulse.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic [SYNC_STAGES-1:0] clear_sync_q, clear_sync_d;
  logic                   load_prev_q, load_prev_d;
  logic                   clear_prev_q, clear_prev_d;
  logic                   load_p_q, load_p_d;
  logic                   clear_p_q, clear_p_d;

  always_comb begin
    load_sync_d  = {load_sync_q[SYNC_STAGES-2:0], btn_load};
    clear_sync_d = {clear_sync_q[SYNC_STAGES-2:0], btn_clear};
    load_prev_d  = load_sync_q[SYNC_STAGES-1];
    clear_prev_d = clear_sync_q[SYNC_STAGES-1];
    load_p_d     = load_sync_q[SYNC_STAGES-1] & ~load_prev_q;
    clear_p_d    = clear_sync_q[SYNC_STAGES-1] & ~clear_prev_q;
  end

  // -------------------------------------------------------------------------
  // Operand / result datapath and control FSM
  // -------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [WIDTH-1:0]     add_x_q, add_x_d;
  logic [WIDTH-1:0]     add_y_q, add_y_d;
  logic [WIDTH:0]       result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic [CNT_WIDTH-1:0] ops_count_q, ops_count_d;

  always_comb begin
    // NOTE: every _d starts as its current _q so paths that do not assign
    // it hold state instead of inferring a latch.
    state_d        = state_q;
    add_x_d        = add_x_q;
    add_y_d        = add_y_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    ops_count_d    = ops_count_q;

    if (clear_p_q) begin
      // Clear has priority over a coincident load; the counter survives.
      state_d        = S_A;
      add_x_d        = '0;
      add_y_d        = '0;
      result_d       = '0;
      result_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_A: begin
          if (load_p_q) begin
            add_x_d = sw;
            state_d = S_B;
          end
        end
        S_B: begin
          if (load_p_q) begin
            add_y_d = sw;
            state_d = S_SUM;
          end
        end
        S_SUM: begin
          // Operands have been stable on the adder for a full cycle here.
          // A load pulse in this state is dropped.
          result_d       = {add_cout, add_s};
          result_valid_d = 1'b1;
          ops_count_d    = ops_count_q + CNT_WIDTH'(1);
          state_d        = S_SHOW;
        end
        S_SHOW: begin
          if (load_p_q) begin
            add_x_d        = sw;
            result_valid_d = 1'b0;
            state_d        = S_B;
          end
        end
      endcase
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_sync_q    <= '0;
      clear_sync_q   <= '0;
      load_prev_q    <= 1'b0;
      clear_prev_q   <= 1'b0;
      load_p_q       <= 1'b0;
      clear_p_q      <= 1'b0;
      state_q        <= S_A;
      add_x_q        <= '0;
      add_y_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ops_count_q    <= '0;
    end else begin
      load_sync_q    <= load_sync_d;
      clear_sync_q   <= clear_sync_d;
      load_prev_q    <= load_prev_d;
      clear_prev_q   <= clear_prev_d;
      load_p_q       <= load_p_d;
      clear_p_q      <= clear_p_d;
      state_q        <= state_d;
      add_x_q        <= add_x_d;
      add_y_q        <= add_y_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ops_count_q    <= ops_count_d;
    end
  end

  assign add_x        = add_x_q;
  assign add_y        = add_y_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign state        = state_q;
  assign ops_count    = ops_count_q;

endmodule

// File: doc/adder_input_sequencer.md
Name: adder_input_sequencer

Overview:
- Sequential front/back end for the combinational 4-bit ripple adder.
- Captures two operands from slide switches on successive presses of a load button and drives them onto the adder's X/Y inputs.
- Samples the adder's sum and carry-out, then holds a registered result plus status for display.
- Sits between board I/O (switches, buttons) and the adder.

Parameters:
- WIDTH, 4, operand width; must equal adder width.
- SYNC_STAGES, 2, flip-flop stages in each button synchronizer (>=2).
- CNT_WIDTH, 8, width of completed-operation counter.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- sw  input  WIDTH  operand value from switches; quasi-static.
- btn_load  input  1  raw, asynchronous load button; active-high.
- btn_clear  input  1  raw, asynchronous clear button; active-high.
- add_x  output  WIDTH  operand A to adder X; registered.
- add_y  output  WIDTH  operand B to adder Y; registered.
- add_s  input  WIDTH  adder sum S.
- add_cout  input  1  adder carry-out.
- result  output  WIDTH+1  registered {carry, sum}.
- result_valid  output  1  high while result holds a completed sum.
- state  output  2  FSM state encoding, for LEDs.
- ops_count  output  CNT_WIDTH  number of completed additions.

Behaviour:
- Reset (resetn low, asynchronous):
  - add_x, add_y, result and ops_count all 0.
  - result_valid 0; state = S_A (2'b00).
  - Synchronizer and edge-detect flops cleared.
- Deassertion of reset takes effect on the next rising clk.
- Button conditioning:
  - Each button passes through SYNC_STAGES flops, then a rising-edge detector.
  - The detector produces a single 1-cycle pulse (load_p, clear_p) per press, regardless of hold length.
  - Latency: raw rise to pulse = SYNC_STAGES+1 cycles.
- FSM states: S_A=00, S_B=01, S_SUM=10, S_SHOW=11.
- S_A: on load_p, add_x <= sw; go to S_B.
- S_B: on load_p, add_y <= sw; go to S_SUM.
- S_SUM (exactly 1 cycle; add_x/add_y stable for 1 full cycle before sampling):
  - result <= {add_cout, add_s}.
  - result_valid <= 1.
  - ops_count <= ops_count+1.
  - Go to S_SHOW.
  - Any load_p arriving in S_SUM is ignored (dropped, not queued).
- S_SHOW: result held.
  - On load_p: add_x <= sw; add_y unchanged; result_valid <= 0; result unchanged; go to S_B.
- Timing: load_p for B sampled at edge N → state S_SUM after N → result/result_valid updated at edge N+1.
- Clear (clear_p, any state):
  - add_x, add_y, result <= 0; result_valid <= 0; state <= S_A.
  - ops_count NOT cleared.
  - If clear_p and load_p occur in the same cycle, clear wins and load is discarded.
- Arithmetic:
  - result is WIDTH+1 bits, so there is no overflow loss.
  - ops_count wraps from 2^CNT_WIDTH−1 to 0 silently.
- The block does not compute the sum itself; result must equal whatever add_s/add_cout present during S_SUM.
- sw changing while in S_B/S_SHOW does not affect add_x/add_y until the next capture.
- Reset mid-operation (any state, including S_SUM): immediate return to reset values; no partial capture, no count increment.

Test Plan:
- Reset, press load with sw=3, press load with sw=5, adder model connected → result=5'b01000, result_valid=1, ops_count=1, state=11.
- Operands 15 and 1 → result=5'b10000 (carry set); then 15 and 15 → result=5'b11110, ops_count=2.
- Hold btn_load high 50 cycles with sw=7 from S_A → only add_x=7 captured, state=S_B; release, change sw=9, press again → add_y=9 and result 5'b10000.
- In S_SHOW with result=8, assert btn_load and btn_clear so pulses coincide → state=S_A, result=0, result_valid=0, add_x=0, ops_count unchanged.
- Assert resetn=0 for 1 cycle while state=S_B with add_x=6 → all outputs 0 asynchronously (before next clk edge), state=00.
- Force ops_count to 255 (CNT_WIDTH=8), complete one addition → ops_count=0, result still correct.
